// File: rtl/serial_bus_master.sv
// ---------------------------------------------------------------------------
// serial_bus_master
//
// Initiator end of the serial master/slave bus. One parallel request from the
// host (slave select, read/write, single/burst, start address, word count) is
// turned into a serial control frame on `control`, followed either by
// bit-serial write data on `wD` or by bit-serial read data collected from `rD`.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   req        host request pulse, sampled only while idle
//   req_slave  target slave ID
//   req_write  1 = write, 0 = read
//   req_burst  1 = burst transaction
//   req_addr   start address (the slave increments it, not the master)
//   req_len    word count; 0 -> 1, saturates at MAX_BURST, ignored if single
//   wr_data    next write word from the host
//   wr_req     pulse: wr_data was latched, host must present the next word
//   rd_data    last received read word
//   rd_valid   pulse: rd_data has just been updated
//   busy       high whenever a transaction is in progress
//   done       pulse on normal completion
//   err        pulse on ready timeout abort
//   control    serial control frame to the slave
//   wD         serial write data, MSB first
//   valid      write data valid
//   last       final word of the transaction is on the wire
//   rD         serial read data from the slave
//   ready      slave ready
// ---------------------------------------------------------------------------
module serial_bus_master #(
    parameter int ADDR_DEPTH = 2000,
    parameter int SLAVES     = 3,
    parameter int DATA_WIDTH = 32,
    parameter int S_ID_WIDTH = $clog2(SLAVES + 1),
    parameter int MAX_BURST  = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req,
    input  logic [S_ID_WIDTH-1:0]             req_slave,
    input  logic                              req_write,
    input  logic                              req_burst,
    input  logic [$clog2(ADDR_DEPTH)-1:0]     req_addr,
    input  logic [$clog2(MAX_BURST+1)-1:0]    req_len,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    output logic                              wr_req,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic                              rd_valid,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic                              control,
    output logic                              wD,
    output logic                              valid,
    output logic                              last,
    input  logic                              rD,
    input  logic                              ready
);

    localparam int ADDR_WIDTH = $clog2(ADDR_DEPTH);
    localparam int FRAME_LEN  = 3 + S_ID_WIDTH + 2 + ADDR_WIDTH;
    localparam int LEN_WIDTH  = $clog2(MAX_BURST + 1);
    localparam int FCNT_WIDTH = $clog2(FRAME_LEN);
    localparam int BCNT_WIDTH = $clog2(DATA_WIDTH);
    localparam int TCNT_WIDTH = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        FRAME,
        WAIT_RDY,
        WRITE,
        READ
    } state_t;

    state_t                  state;
    logic                    is_write;
    logic [LEN_WIDTH-1:0]    words_left;
    logic [FRAME_LEN-2:0]    frame_sr;
    logic [FCNT_WIDTH-1:0]   fcnt;
    logic [BCNT_WIDTH-1:0]   bcnt;
    logic [TCNT_WIDTH-1:0]   tcnt;
    logic [DATA_WIDTH-1:0]   tx_sr;
    logic [DATA_WIDTH-2:0]   rx_sr;

    logic [LEN_WIDTH-1:0]    eff_len;
    logic [FRAME_LEN-1:0]    frame_word;

    // The host's word count is normalised before it is latched: single
    // transfers always move one word, a zero burst length still moves one
    // word, and anything above MAX_BURST is clipped so the slave never sees
    // a burst longer than it supports.
    always_comb begin
        eff_len = LEN_WIDTH'(1);
        if (req_burst) begin
            if (req_len == '0) begin
                eff_len = LEN_WIDTH'(1);
            end else if (req_len > LEN_WIDTH'(MAX_BURST)) begin
                eff_len = LEN_WIDTH'(MAX_BURST);
            end else begin
                eff_len = req_len;
            end
        end
    end

    // Control frame as it goes on the wire, MSB first: a fixed 3'b111 start
    // marker so the slave can find the frame, then slave ID, direction,
    // burst flag and start address.
    always_comb begin
        frame_word = {3'b111, req_slave, req_write, req_burst, req_addr};
    end

    // Transaction sequencer. Every bus and host output is a flop so nothing
    // combinational reaches the interconnect. The frame MSB goes straight to
    // `control` when the request is accepted, so the shift register only has
    // to hold the remaining FRAME_LEN-1 bits. The timeout counter measures
    // consecutive cycles with ready low and is cleared whenever the slave is
    // ready, so a short stall mid-word or between burst words does not eat
    // into the budget of a later stall. Words are counted down; when the
    // final word starts, `last` is raised (for reads already while waiting
    // for the slave, so it covers every sampled bit of that word).
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            is_write   <= 1'b0;
            words_left <= '0;
            frame_sr   <= '0;
            fcnt       <= '0;
            bcnt       <= '0;
            tcnt       <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            wr_req     <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            control    <= 1'b0;
            wD         <= 1'b0;
            valid      <= 1'b0;
            last       <= 1'b0;
        end else begin
            wr_req   <= 1'b0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;

            case (state)
                IDLE: begin
                    if (req) begin
                        state      <= FRAME;
                        busy       <= 1'b1;
                        is_write   <= req_write;
                        words_left <= eff_len;
                        control    <= frame_word[FRAME_LEN-1];
                        frame_sr   <= frame_word[FRAME_LEN-2:0];
                        fcnt       <= '0;
                        bcnt       <= '0;
                        tcnt       <= '0;
                        if (req_write) begin
                            tx_sr  <= wr_data;
                            wr_req <= 1'b1;
                        end
                    end
                end

                FRAME: begin
                    if (fcnt == FCNT_WIDTH'(FRAME_LEN - 1)) begin
                        state   <= WAIT_RDY;
                        control <= 1'b0;
                        tcnt    <= '0;
                        if (!is_write) begin
                            last <= (words_left == LEN_WIDTH'(1));
                        end
                    end else begin
                        control  <= frame_sr[FRAME_LEN-2];
                        frame_sr <= {frame_sr[FRAME_LEN-3:0], 1'b0};
                        fcnt     <= fcnt + FCNT_WIDTH'(1);
                    end
                end

                WAIT_RDY: begin
                    if (ready) begin
                        tcnt <= '0;
                        if (is_write) begin
                            state <= WRITE;
                            valid <= 1'b1;
                            last  <= (words_left == LEN_WIDTH'(1));
                            wD    <= tx_sr[DATA_WIDTH-1];
                            tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                            bcnt  <= '0;
                        end else begin
                            state <= READ;
                            rx_sr <= {rx_sr[DATA_WIDTH-3:0], rD};
                            bcnt  <= BCNT_WIDTH'(1);
                        end
                    end else if (tcnt == TCNT_WIDTH'(TIMEOUT - 1)) begin
                        state   <= IDLE;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        control <= 1'b0;
                        wD      <= 1'b0;
                        valid   <= 1'b0;
                        last    <= 1'b0;
                        tcnt    <= '0;
                    end else begin
                        tcnt <= tcnt + TCNT_WIDTH'(1);
                    end
                end

                WRITE: begin
                    if (bcnt != BCNT_WIDTH'(DATA_WIDTH - 1)) begin
                        wD    <= tx_sr[DATA_WIDTH-1];
                        tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                        bcnt  <= bcnt + BCNT_WIDTH'(1);
                    end else if (words_left != LEN_WIDTH'(1)) begin
                        wD         <= wr_data[DATA_WIDTH-1];
                        tx_sr      <= {wr_data[DATA_WIDTH-2:0], 1'b0};
                        wr_req     <= 1'b1;
                        bcnt       <= '0;
                        words_left <= words_left - LEN_WIDTH'(1);
                        last       <= (words_left == LEN_WIDTH'(2));
                    end else begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        valid      <= 1'b0;
                        last       <= 1'b0;
                        wD         <= 1'b0;
                        bcnt       <= '0;
                        words_left <= '0;
                    end
                end

                READ: begin
                    if (ready) begin
                        tcnt <= '0;
                        if (bcnt == BCNT_WIDTH'(DATA_WIDTH - 1)) begin
                            rd_data    <= {rx_sr, rD};
                            rd_valid   <= 1'b1;
                            bcnt       <= '0;
                            words_left <= words_left - LEN_WIDTH'(1);
                            if (words_left == LEN_WIDTH'(1)) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                last  <= 1'b0;
                            end else begin
                                state <= WAIT_RDY;
                                last  <= (words_left == LEN_WIDTH'(2));
                            end
                        end else begin
                            rx_sr <= {rx_sr[DATA_WIDTH-3:0], rD};
                            bcnt  <= bcnt + BCNT_WIDTH'(1);
                        end
                    end else if (tcnt == TCNT_WIDTH'(TIMEOUT - 1)) begin
                        state   <= IDLE;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        control <= 1'b0;
                        wD      <= 1'b0;
                        valid   <= 1'b0;
                        last    <= 1'b0;
                        tcnt    <= '0;
                        bcnt    <= '0;
                    end else begin
                        tcnt <= tcnt + TCNT_WIDTH'(1);
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    control <= 1'b0;
                    wD      <= 1'b0;
                    valid   <= 1'b0;
                    last    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_master.sv
// ---------------------------------------------------------------------------
// tb_serial_bus_master
//
// Plays both the host and the slave around serial_bus_master. The host side
// feeds write words on each wr_req; the slave side drives ready/rD from a
// bit queue with optional stall gaps. Observed frames, write bit streams,
// read words and completion pulses are compared with values computed from
// the bus rules (frame layout, word count rules, timeout length).
// ---------------------------------------------------------------------------
module tb_serial_bus_master;

    localparam int ADDR_DEPTH = 2000;
    localparam int SLAVES     = 3;
    localparam int DW         = 32;
    localparam int S_ID_W     = $clog2(SLAVES + 1);
    localparam int MAX_BURST  = 16;
    localparam int TIMEOUT    = 255;
    localparam int AW         = $clog2(ADDR_DEPTH);
    localparam int FRAME_LEN  = 3 + S_ID_W + 2 + AW;
    localparam int LEN_W      = $clog2(MAX_BURST + 1);

    logic              clk;
    logic              rst;
    logic              req;
    logic [S_ID_W-1:0] req_slave;
    logic              req_write;
    logic              req_burst;
    logic [AW-1:0]     req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DW-1:0]     wr_data;
    logic              wr_req;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic              err;
    logic              control;
    logic              wD;
    logic              valid;
    logic              last;
    logic              rD;
    logic              ready;

    int testCount = 0;
    int failCount = 0;

    logic [DW-1:0] wordsArr [0:MAX_BURST];

    serial_bus_master #(
        .ADDR_DEPTH(ADDR_DEPTH),
        .SLAVES    (SLAVES),
        .DATA_WIDTH(DW),
        .S_ID_WIDTH(S_ID_W),
        .MAX_BURST (MAX_BURST),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_slave(req_slave),
        .req_write(req_write),
        .req_burst(req_burst),
        .req_addr (req_addr),
        .req_len  (req_len),
        .wr_data  (wr_data),
        .wr_req   (wr_req),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .control  (control),
        .wD       (wD),
        .valid    (valid),
        .last     (last),
        .rD       (rD),
        .ready    (ready)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something upstream never terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Word the host should offer at a given position of the write sequence.
    function automatic logic [DW-1:0] hostWord(input int idx);
        if (idx <= MAX_BURST) return wordsArr[idx];
        return DW'($urandom);
    endfunction

    task automatic randomWords();
        for (int i = 0; i <= MAX_BURST; i++) wordsArr[i] = DW'($urandom);
    endtask

    // Runs one complete transaction, acting as host and slave, then checks
    // everything observed against what the bus rules predict.
    task automatic applyStimulus(input int slv, input bit wr, input bit bst,
                                 input int addr, input int len,
                                 input int gapAt, input int gapLen,
                                 input bit noReady, input bit busyReq);
        int nExp, total, bitsSent, hostIdx, wrReqCount, doneCount, errCount;
        int doneCyc, errCyc, lastRdCyc, rdCount, rdTimingBad, lastBad;
        int ctrlStray, gapLeft, validCount, firstValid, lastValid, quietBad;
        bit gapUsed, finished;
        logic endBus;
        logic [63:0] expFrame, obsFrame;
        logic [DW-1:0] tmpWord, obsWord;
        bit wrBits[$];
        bit lastBits[$];

        if (!bst) nExp = 1;
        else if (len == 0) nExp = 1;
        else if (len > MAX_BURST) nExp = MAX_BURST;
        else nExp = len;
        total = nExp * DW;

        expFrame = (64'd7 << (FRAME_LEN - 3)) | (64'(slv) << (AW + 2)) |
                   (64'(wr) << (AW + 1)) | (64'(bst) << AW) | 64'(addr);

        bitsSent = 0; hostIdx = 0; wrReqCount = 0; doneCount = 0; errCount = 0;
        doneCyc = -1; errCyc = -1; lastRdCyc = -1; rdCount = 0; rdTimingBad = 0;
        lastBad = 0; ctrlStray = 0; gapLeft = 0; validCount = 0; firstValid = -1;
        lastValid = -1; quietBad = 0; gapUsed = 0; finished = 0; endBus = 1'b1;

        @(negedge clk);
        ready     = 1'b0;
        rD        = 1'b0;
        req       = 1'b1;
        req_slave = S_ID_W'(slv);
        req_write = wr;
        req_burst = bst;
        req_addr  = AW'(addr);
        req_len   = LEN_W'(len);
        wr_data   = wordsArr[0];
        @(negedge clk);
        req       = 1'b0;
        req_slave = S_ID_W'($urandom);
        req_addr  = AW'($urandom);
        req_write = 1'($urandom);
        req_burst = 1'($urandom);
        req_len   = LEN_W'($urandom);

        obsFrame = '0;
        for (int j = 0; j < FRAME_LEN; j++) begin
            obsFrame = {obsFrame[62:0], control};
            if (j == 0) checkOutput("busy_rise", 64'(busy), 64'd1);
            if (wr_req) begin
                wrReqCount++;
                hostIdx++;
                wr_data = hostWord(hostIdx);
            end
            @(negedge clk);
        end
        checkOutput("frame", obsFrame, expFrame);

        for (int cyc = 0; cyc < total * 2 + TIMEOUT + 100; cyc++) begin
            if (valid) begin
                wrBits.push_back(wD);
                lastBits.push_back(last);
                if (firstValid < 0) firstValid = cyc;
                lastValid = cyc;
                validCount++;
            end
            if (wr_req) begin
                wrReqCount++;
                hostIdx++;
                wr_data = hostWord(hostIdx);
            end
            if (rd_valid) begin
                tmpWord = (rdCount <= MAX_BURST) ? wordsArr[rdCount] : '0;
                checkOutput($sformatf("rd_word%0d", rdCount), 64'(rd_data), 64'(tmpWord));
                if (bitsSent != (rdCount + 1) * DW) rdTimingBad++;
                rdCount++;
                lastRdCyc = cyc;
            end
            if (done) begin doneCount++; doneCyc = cyc; end
            if (err) begin errCount++; errCyc = cyc; end
            if (control) ctrlStray++;
            if (!busy) begin
                finished = 1;
                endBus = control | wD | valid | last;
                break;
            end
            if (!wr && (last != (bitsSent >= total - DW))) lastBad++;
            if (wr && last && !valid) lastBad++;

            req = busyReq && (cyc == 3);
            if (busyReq && cyc == 3) begin
                req_write = 1'b1;
                req_burst = 1'b0;
                req_addr  = AW'(addr + 7);
            end

            if (noReady) begin
                ready = 1'b0;
                rD    = 1'($urandom);
            end else if (wr) begin
                ready = (cyc >= gapLen);
            end else begin
                if (!gapUsed && gapLen > 0 && bitsSent == gapAt) begin
                    gapUsed = 1;
                    gapLeft = gapLen;
                end
                if (gapLeft > 0) begin
                    ready = 1'b0;
                    rD    = 1'($urandom);
                    gapLeft--;
                end else if (bitsSent < total) begin
                    ready   = 1'b1;
                    tmpWord = wordsArr[bitsSent / DW];
                    rD      = tmpWord[DW - 1 - (bitsSent % DW)];
                    bitsSent++;
                end else begin
                    ready = 1'b0;
                end
            end
            @(negedge clk);
        end
        ready = 1'b0;
        req   = 1'b0;

        checkOutput("txn_finished", 64'(finished), 64'd1);
        checkOutput("ctrl_outside_frame", 64'(ctrlStray), 64'd0);
        checkOutput("bus_idle_at_end", 64'(endBus), 64'd0);

        if (noReady) begin
            checkOutput("timeout_err_cycle", 64'(errCyc), 64'(TIMEOUT));
            checkOutput("timeout_err_count", 64'(errCount), 64'd1);
            checkOutput("timeout_no_done", 64'(doneCount), 64'd0);
        end else begin
            checkOutput("done_count", 64'(doneCount), 64'd1);
            checkOutput("err_count", 64'(errCount), 64'd0);
            checkOutput("last_window", 64'(lastBad), 64'd0);
            if (wr) begin
                checkOutput("valid_cycles", 64'(validCount), 64'(total));
                checkOutput("valid_contiguous", 64'(lastValid - firstValid + 1), 64'(validCount));
                checkOutput("wr_req_count", 64'(wrReqCount), 64'(nExp));
                for (int w = 0; w < nExp && (w + 1) * DW <= wrBits.size(); w++) begin
                    obsWord = '0;
                    for (int b = 0; b < DW; b++) obsWord = {obsWord[DW-2:0], wrBits[w * DW + b]};
                    checkOutput($sformatf("wr_word%0d", w), 64'(obsWord), 64'(wordsArr[w]));
                end
                for (int i = 0; i < lastBits.size(); i++) begin
                    if (lastBits[i] != (i >= total - DW)) lastBad++;
                end
                checkOutput("last_on_final_word", 64'(lastBad), 64'd0);
            end else begin
                checkOutput("rd_valid_count", 64'(rdCount), 64'(nExp));
                checkOutput("rd_valid_timing", 64'(rdTimingBad), 64'd0);
                checkOutput("done_after_data", 64'(doneCyc >= lastRdCyc && lastRdCyc >= 0), 64'd1);
            end
        end

        @(negedge clk);
        checkOutput("pulses_single_cycle", 64'({done, err, rd_valid, wr_req}), 64'd0);

        if (busyReq) begin
            for (int i = 0; i < FRAME_LEN + 5; i++) begin
                if (busy || control) quietBad++;
                @(negedge clk);
            end
            checkOutput("busy_req_ignored", 64'(quietBad), 64'd0);
        end
    endtask

    // Main sequence: reset, directed cases, boundary cases, random cases,
    // then a reset in the middle of a write.
    initial begin
        int vcount;
        int slv, addr, len, gapAt, gapLen;
        bit wr, bst;

        rst = 1'b1; req = 1'b0; req_slave = '0; req_write = 1'b0; req_burst = 1'b0;
        req_addr = '0; req_len = '0; wr_data = '0; rD = 1'b0; ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    64'({control, wD, valid, last, busy, done, err, wr_req, rd_valid}), 64'd0);
        checkOutput("reset_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        randomWords();
        wordsArr[0] = 32'hDEADBEEF;
        applyStimulus(1, 1'b1, 1'b0, 5, 0, 0, 0, 1'b0, 1'b0);

        randomWords();
        wordsArr[0] = 32'hA5A50F0F;
        applyStimulus(2, 1'b0, 1'b0, 10, 0, 0, 0, 1'b0, 1'b0);

        randomWords();
        wordsArr[0] = 32'h11111111;
        wordsArr[1] = 32'h22222222;
        wordsArr[2] = 32'h33333333;
        applyStimulus(1, 1'b1, 1'b1, 100, 3, 0, 0, 1'b0, 1'b1);

        randomWords();
        applyStimulus(3, 1'b0, 1'b1, 200, 2, 10, 5, 1'b0, 1'b0);

        randomWords();
        applyStimulus(2, 1'b0, 1'b0, 33, 0, 0, 0, 1'b1, 1'b0);

        randomWords();
        applyStimulus(0, 1'b1, 1'b1, 1999, 4, 0, 0, 1'b1, 1'b0);

        randomWords();
        applyStimulus(1, 1'b1, 1'b1, 0, 0, 0, 3, 1'b0, 1'b0);

        randomWords();
        applyStimulus(2, 1'b0, 1'b1, 77, 20, DW, 4, 1'b0, 1'b0);

        randomWords();
        applyStimulus(3, 1'b1, 1'b0, 512, 5, 0, 0, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            randomWords();
            slv    = $urandom_range(0, 3);
            wr     = 1'($urandom_range(0, 1));
            bst    = 1'($urandom_range(0, 1));
            addr   = $urandom_range(0, ADDR_DEPTH - 1);
            len    = $urandom_range(0, 8);
            gapAt  = $urandom_range(0, 64);
            gapLen = $urandom_range(0, 6);
            applyStimulus(slv, wr, bst, addr, len, gapAt, gapLen, 1'b0, 1'b0);
        end

        randomWords();
        @(negedge clk);
        ready = 1'b0; req = 1'b1; req_slave = 2'd1; req_write = 1'b1; req_burst = 1'b1;
        req_len = LEN_W'(4); req_addr = AW'(300); wr_data = wordsArr[0];
        @(negedge clk);
        req = 1'b0;
        ready = 1'b1;
        vcount = 0;
        for (int c = 0; c < 200 && vcount < 10; c++) begin
            @(negedge clk);
            if (valid) vcount++;
        end
        checkOutput("rst_abort_reached_bit10", 64'(vcount), 64'd10);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_abort_outputs",
                    64'({control, wD, valid, last, busy, done, err, wr_req, rd_valid}), 64'd0);
        rst = 1'b0;
        ready = 1'b0;
        vcount = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || err || busy) vcount++;
        end
        checkOutput("rst_abort_no_pulse", 64'(vcount), 64'd0);

        randomWords();
        applyStimulus(1, 1'b0, 1'b1, 42, 3, 40, 2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
